// File: rtl/nios2_switch_pio_pkg.sv
// -----------------------------------------------------------------------------
// nios2_pio_pkg
// Shared definitions for the switch/button input PIO:
//   - Avalon word addresses of the register map
//   - edge capture mode encoding
// -----------------------------------------------------------------------------
package nios2_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_mode_e;

endpackage

// File: rtl/nios2_switch_pio_if.sv
// -----------------------------------------------------------------------------
// nios2_switch_pio_if
// Avalon-MM slave bus of the switch PIO.
//   address    [1:0]  word address
//   chipselect        slave select
//   write_n           active-low write strobe, qualified by chipselect
//   writedata  [31:0] write data
//   readdata   [31:0] registered read data
// Bus semantics: a write completes on the clk edge where chipselect=1 and
// write_n=0 (no wait states). Reads need no strobe: readdata always holds the
// register selected by address on the previous edge, and reading has no side
// effects.
// -----------------------------------------------------------------------------
interface nios2_switch_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios2_pio_debounce.sv
// -----------------------------------------------------------------------------
// nios2_pio_debounce
// One input bit: synchroniser chain followed by an optional debounce filter.
// Build option: NIOS2_SWITCH_PIO_DEBOUNCE_EN adds the filter; otherwise the
// output is the last synchroniser stage.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   din    asynchronous input bit
//   dout   synchronised (and, if enabled, debounced) bit
// -----------------------------------------------------------------------------
module nios2_pio_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;

  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], din};
  end

  assign sync_out = sync[SYNC_STAGES-1];

`ifdef NIOS2_SWITCH_PIO_DEBOUNCE_EN
  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          filt;

  // For a single bit, "sync changed while a change is pending" can only mean
  // it returned to filt, so sync == filt covers both restart conditions.
  // The counter is cleared on reaching CNT_MAX, so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync_out == filt) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      filt <= sync_out;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign dout = filt;
`else
  assign dout = sync_out;
`endif

endmodule

// File: rtl/nios2_switch_pio.sv
// -----------------------------------------------------------------------------
// nios2_switch_pio
// Avalon-MM input PIO for board switches/buttons: synchronises (optionally
// debounces) in_port, captures per-bit edges and raises a maskable level irq.
// Build option: NIOS2_SWITCH_PIO_DEBOUNCE_EN enables per-bit debounce.
// Ports:
//   clk      system clock (single domain)
//   reset    synchronous, active-high
//   bus      Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   in_port  asynchronous switch inputs, DATA_WIDTH bits
//   irq      registered level interrupt
// Register map: 0 DATA (RO), 1 IRQMASK (RW), 2 reserved (reads 0),
//               3 EDGECAPTURE (write 1 to clear).
// -----------------------------------------------------------------------------
module nios2_switch_pio
  import nios2_pio_pkg::*;
#(
  parameter int DATA_WIDTH      = 18,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_MODE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  nios2_switch_pio_if.slave     bus,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE);

  logic [DATA_WIDTH-1:0] filt;
  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH-1:0] irqmask;
  logic [DATA_WIDTH-1:0] edgecapture;
  logic [DATA_WIDTH-1:0] ev;
  logic [DATA_WIDTH-1:0] clr;
  logic [31:0]           rd_mux;
  logic                  wr_en;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_in
    nios2_pio_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .din   (in_port[i]),
      .dout  (filt[i])
    );
  end

  assign wr_en = bus.chipselect && !bus.write_n;

  always_comb begin
    ev = '0;
    case (MODE)
      EDGE_RISE: ev = filt & ~prev;
      EDGE_FALL: ev = ~filt & prev;
      default:   ev = filt ^ prev;
    endcase
  end

  assign clr = (wr_en && bus.address == ADDR_EDGECAP) ? bus.writedata[DATA_WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA:    rd_mux = 32'(filt);
      ADDR_IRQMASK: rd_mux = 32'(irqmask);
      ADDR_EDGECAP: rd_mux = 32'(edgecapture);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev         <= '0;
      irqmask      <= '0;
      edgecapture  <= '0;
      bus.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      prev <= filt;
      if (wr_en && bus.address == ADDR_IRQMASK)
        irqmask <= bus.writedata[DATA_WIDTH-1:0];
      // New edge ORed in after the clear: a same-cycle edge keeps the bit set.
      edgecapture  <= (edgecapture & ~clr) | ev;
      bus.readdata <= rd_mux;
      irq          <= |(edgecapture & irqmask);
    end
  end

  // Upper writedata bits have no destination when DATA_WIDTH < 32.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, bus.writedata};

endmodule

// File: tb/tb_nios2_switch_pio.sv
module tb_nios2_switch_pio;
  localparam int DW  = 18;
  localparam int SS  = 2;
  localparam int DBC = 8;
`ifdef NIOS2_SWITCH_PIO_DEBOUNCE_EN
  localparam int LAT = SS + DBC + 1;
`else
  localparam int LAT = SS + 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nios2_switch_pio_if bus0 ();
  nios2_switch_pio_if bus1 ();
  logic [DW-1:0] in_port0, in_port1;
  logic          irq0, irq1;

  nios2_switch_pio #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .EDGE_MODE(0), .DEBOUNCE_CYCLES(DBC))
    dut0 (.clk(clk), .reset(reset), .bus(bus0), .in_port(in_port0), .irq(irq0));
  nios2_switch_pio #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .EDGE_MODE(2), .DEBOUNCE_CYCLES(DBC))
    dut1 (.clk(clk), .reset(reset), .bus(bus1), .in_port(in_port1), .irq(irq1));

  int n_cmp = 0;
  int n_err = 0;

  // driver tasks
  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] data);
    @(negedge clk);
    if (d == 0) begin
      bus0.address = a; bus0.chipselect = 1'b1; bus0.write_n = 1'b0; bus0.writedata = data;
    end else begin
      bus1.address = a; bus1.chipselect = 1'b1; bus1.write_n = 1'b0; bus1.writedata = data;
    end
    @(posedge clk); #1;
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
    bus1.chipselect = 1'b0; bus1.write_n = 1'b1;
  endtask

  task automatic rd(input int d, input logic [1:0] a, output logic [31:0] data);
    @(negedge clk);
    if (d == 0) bus0.address = a; else bus1.address = a;
    @(posedge clk); #1;
    data = (d == 0) ? bus0.readdata : bus1.readdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    int k;
    reset = 1'b1;
    in_port0 = 18'h3FFFF;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus0.readdata !== 32'h0) begin n_err++; $display("FAIL reset_readdata got %h exp %h", bus0.readdata, 32'h0); end
    n_cmp++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b exp 0", irq0); end
    @(negedge clk);
    reset = 1'b0;
    bus0.address = 2'd0;
    for (k = 1; k <= LAT + 2; k++) begin
      @(posedge clk); #1;
      if (bus0.readdata === 32'h0003FFFF) break;
    end
    n_cmp++; if (bus0.readdata !== 32'h0003FFFF) begin n_err++; $display("FAIL reset_data_after got %h exp %h", bus0.readdata, 32'h0003FFFF); end
    // prev resets to 0, so the switches already high look like rising edges
    rd(0, 2'd3, v);
    n_cmp++; if (v !== 32'h0003FFFF) begin n_err++; $display("FAIL reset_edgecap got %h exp %h", v, 32'h0003FFFF); end
    n_cmp++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL reset_irq_masked got %b exp 0", irq0); end
  endtask

  task automatic test_rise_only();
    logic [31:0] v;
    @(negedge clk) in_port0 = '0;
    repeat (LAT + 2) @(posedge clk);
    wr(0, 2'd3, 32'hFFFFFFFF);
    rd(0, 2'd3, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL fall_ignored got %h exp %h", v, 32'h0); end
    rd(0, 2'd1, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL mask_reset got %h exp %h", v, 32'h0); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] v;
    int k;
    wr(0, 2'd1, 32'hFFFFFFFF);
    rd(0, 2'd1, v);
    n_cmp++; if (v !== 32'h0003FFFF) begin n_err++; $display("FAIL mask_width got %h exp %h", v, 32'h0003FFFF); end
    wr(0, 2'd1, 32'h1);
    rd(0, 2'd1, v);
    n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL mask_write got %h exp %h", v, 32'h1); end
    @(negedge clk) in_port0[0] = 1'b1;
    for (k = 1; k <= LAT + 4; k++) begin
      @(posedge clk); #1;
      if (irq0 === 1'b1) break;
    end
    n_cmp++; if (k !== LAT + 1) begin n_err++; $display("FAIL irq_latency got %0d exp %0d", k, LAT + 1); end
    rd(0, 2'd3, v);
    n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL edgecap_bit0 got %h exp %h", v, 32'h1); end
    wr(0, 2'd3, 32'h1);
    n_cmp++; if (irq0 !== 1'b1) begin n_err++; $display("FAIL irq_lag got %b exp 1", irq0); end
    @(posedge clk); #1;
    n_cmp++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL irq_clear got %b exp 0", irq0); end
  endtask

  task automatic test_masking();
    logic [31:0] v;
    wr(0, 2'd1, 32'h0);
    @(negedge clk) in_port0[5] = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    rd(0, 2'd3, v);
    n_cmp++; if (v !== 32'h20) begin n_err++; $display("FAIL edgecap_bit5 got %h exp %h", v, 32'h20); end
    n_cmp++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL irq_masked got %b exp 0", irq0); end
    wr(0, 2'd1, 32'h20);
    n_cmp++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL irq_unmask_lag got %b exp 0", irq0); end
    @(posedge clk); #1;
    n_cmp++; if (irq0 !== 1'b1) begin n_err++; $display("FAIL irq_unmask got %b exp 1", irq0); end
    wr(0, 2'd1, 32'h0);
  endtask

  task automatic test_clear_race();
    logic [31:0] v;
    @(negedge clk) in_port0 = in_port0 | 18'h12;
    repeat (LAT + 2) @(posedge clk);
    rd(0, 2'd3, v);
    n_cmp++; if (v !== 32'h32) begin n_err++; $display("FAIL race_pre got %h exp %h", v, 32'h32); end
    // bit 2 edge reaches edgecapture on the LAT-th edge after this change;
    // the W1C is timed to land on that same edge
    @(negedge clk) in_port0[2] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    bus0.address = 2'd3; bus0.chipselect = 1'b1; bus0.write_n = 1'b0; bus0.writedata = 32'h36;
    @(posedge clk); #1;
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
    rd(0, 2'd3, v);
    n_cmp++; if (v !== 32'h4) begin n_err++; $display("FAIL race_set_wins got %h exp %h", v, 32'h4); end
  endtask

`ifdef NIOS2_SWITCH_PIO_DEBOUNCE_EN
  task automatic test_debounce();
    logic [31:0] v;
    logic seen;
    int k;
    @(negedge clk);
    bus0.address = 2'd0;
    in_port0[3] = 1'b1;
    repeat (5) @(negedge clk);
    in_port0[3] = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus0.readdata[3] !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL glitch_data got %b exp 0", seen); end
    rd(0, 2'd3, v);
    n_cmp++; if (v[3] !== 1'b0) begin n_err++; $display("FAIL glitch_edge got %b exp 0", v[3]); end
    @(negedge clk);
    bus0.address = 2'd0;
    in_port0[3] = 1'b1;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus0.readdata[3] === 1'b1) break;
    end
    n_cmp++; if (k !== DBC + SS + 1) begin n_err++; $display("FAIL debounce_latency got %0d exp %0d", k, DBC + SS + 1); end
  endtask
`endif

  task automatic test_any_edge();
    logic [31:0] v;
    wr(1, 2'd2, 32'hFFFFFFFF);
    rd(1, 2'd2, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reserved_read got %h exp %h", v, 32'h0); end
    rd(1, 2'd1, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reserved_alias got %h exp %h", v, 32'h0); end
    @(negedge clk) in_port1[0] = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    rd(1, 2'd3, v);
    n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL any_rise got %h exp %h", v, 32'h1); end
    wr(1, 2'd3, 32'h1);
    rd(1, 2'd3, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL any_clear got %h exp %h", v, 32'h0); end
    @(negedge clk) in_port1[0] = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    rd(1, 2'd3, v);
    n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL any_fall got %h exp %h", v, 32'h1); end
  endtask

  initial begin
    bus0.address = '0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
    bus1.address = '0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.writedata = '0;
    in_port0 = '0;
    in_port1 = '0;
    test_reset();
    test_rise_only();
    test_edge_irq();
    test_masking();
    test_clear_race();
`ifdef NIOS2_SWITCH_PIO_DEBOUNCE_EN
    test_debounce();
`endif
    test_any_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
